priority_scanner: RTL
=====================

# priority_scanner

Parametrised, sequential successor to the 4-to-2 priority encoder. It accepts a W-bit request vector over a valid/ready handshake. It then emits the index of every set bit, one per output handshake, in priority order: MSB-first or LSB-first, selected by parameter. It sits between request-collecting logic and any consumer that must service all asserted lines, not just the top one. An all-zero vector is reported explicitly rather than producing x or 0.

## Interface
- W, default 8, vector width; legal range 2..64.
- IW, default $clog2(W), index width; derived, do not override.
- MSB_FIRST, default 1; 1 = highest set bit first, 0 = lowest set bit first.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. This is the only reset; the block has one clock.
- i  in  W  request vector; sampled only on an input handshake.
- in_valid  in  1  i is valid.
- in_ready  out  1  block can accept a vector.
- y  out  IW  index of the current highest-priority pending bit.
- out_valid  out  1  y is valid.
- out_ready  in  1  consumer takes y.
- zero  out  1  one-cycle pulse: the accepted vector was all zeros.
- busy  out  1  a vector is being scanned.
- last  out  1  y is the final index of this vector. Present only with PSCAN_LAST_EN.

## Operation
- Internal state:
  - FSM with states IDLE and SCAN.
  - W-bit register pend.
- in_ready = (state==IDLE).
- busy = (state==SCAN).
- out_valid = (state==SCAN).
- IDLE, in_valid=1:
  - i==0: stay IDLE; pend stays 0; zero=1 for the next cycle only.
  - i!=0: pend<=i, go to SCAN.
- SCAN:
  - y = priority index of pend, combinational from the register.
  - MSB_FIRST=1: y = largest n with pend[n]=1. MSB_FIRST=0: y = smallest such n.
- Output handshake (out_valid && out_ready):
  - Clear pend[y].
  - If pend had exactly one bit set, go to IDLE next cycle (pend becomes 0).
- No handshake: pend, y and state all hold. y must stay stable under backpressure.
- Whenever out_valid=0, y=0. There are no x values on y, unlike the old encoder.
- in_valid is ignored in SCAN. A new vector can only be accepted in IDLE.
- Number of output beats per vector = popcount(i). Indices are strictly decreasing (MSB_FIRST=1) or strictly increasing (MSB_FIRST=0).

## Timing
- Reset values: state=IDLE, pend=0, in_ready=1, out_valid=0, y=0, zero=0, busy=0, last=0.
- Reset is asynchronous: asserting rst_n mid-scan drops out_valid and busy immediately and discards pend.
- First release edge: the block accepts on the first rising edge where rst_n=1 and in_valid=1.
- Latency: input handshake at edge k gives out_valid=1 and the first y in the cycle after edge k.
- Throughput, out_ready held high:
  - One index per cycle.
  - A vector with p set bits occupies the block for p cycles.
  - in_ready returns 1 in the cycle after the final output handshake.
  - Total: p+1 cycles per vector.
- Zero vector: accepted at edge k; zero=1 in cycle k+1 only; in_ready stays 1 throughout.
- Back-to-back zero vectors produce back-to-back zero pulses.
- out_ready may toggle freely. Only the cycles where it is high consume indices.

## Configuration
- PSCAN_LAST_EN:
  - Defined: port last is present.
  - last = out_valid && (pend has exactly one bit set).
  - last=1 exactly on the final beat of each vector.
  - last is 0 under reset and in IDLE.
- Undefined: port last and its logic are absent. All other behaviour is identical.

## Test plan
- W=4, MSB_FIRST=1, i=4'b1101, out_ready=1:
  - y=3,2,0 on three consecutive cycles.
  - in_ready=1 on the 4th cycle.
  - last high only with y=0 (macro defined).
- W=4, MSB_FIRST=0, i=4'b1101 -> y=0,2,3; then i=4'b0100 -> single beat y=2.
- Backpressure, W=8, MSB_FIRST=1:
  - i=8'h81, out_ready low for 3 cycles -> y holds 7 and out_valid holds 1.
  - Raise out_ready -> y=7, then y=0.
- Zero input: i=4'b0000 accepted -> zero=1 for exactly one cycle, out_valid stays 0, busy stays 0.
- Reset mid-scan: i=4'b1111 accepted, one beat consumed (y=3), then rst_n=0:
  - out_valid, busy and y go to 0 immediately.
  - After release, i=4'b0010 yields y=1 only.
- Random: 200 $random vectors with random out_ready.
  - Each vector's emitted indices must equal its set bits, in priority order.
  - Every all-zero vector must produce exactly one zero pulse.

Source files
------------

// File: rtl/priority_scanner.sv
// ============================================================================
//  Module   : priority_scanner
//  Purpose  : Accepts a W-bit request vector and emits the index of every set
//             bit, one per output handshake, MSB-first or LSB-first.
//  Options  : PSCAN_LAST_EN adds the 'last' output flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_scanner #(
  parameter int W         = 8,
  parameter int IW        = $clog2(W),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          zero,
  output logic          busy
`ifdef PSCAN_LAST_EN
  ,
  output logic          last
`endif
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SCAN = 1'b1;

  logic [0:0]    r_state;
  logic [W-1:0]  r_pend;
  logic          r_zero;

  logic          w_scan;
  logic          w_accept;
  logic          w_fire;
  logic          w_final;
  logic [IW-1:0] w_idx;
  logic [W-1:0]  w_pend_clr;

  assign w_scan   = (r_state == c_SCAN);
  assign w_accept = (r_state == c_IDLE) && in_valid;
  assign w_fire   = w_scan && out_ready;

  // Later loop iterations win, so the scan direction sets the priority.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        w_idx = '0;
        for (int n = 0; n < W; n++) begin
          if (r_pend[n]) w_idx = IW'(n);
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_idx = '0;
        for (int n = W - 1; n >= 0; n--) begin
          if (r_pend[n]) w_idx = IW'(n);
        end
      end
    end
  endgenerate

  // Pend with the current index removed; empty means this is the final beat.
  assign w_pend_clr = r_pend & ~(W'(1) << w_idx);
  assign w_final    = (w_pend_clr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_pend  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_zero <= w_accept && (i == '0);
      if (r_state == c_IDLE) begin
        if (w_accept && (i != '0)) begin
          r_pend  <= i;
          r_state <= c_SCAN;
        end
      end else begin
        if (w_fire) begin
          r_pend <= w_pend_clr;
          if (w_final) r_state <= c_IDLE;
        end
      end
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign busy      = w_scan;
  assign out_valid = w_scan;
  assign y         = w_scan ? w_idx : '0;
  assign zero      = r_zero;

`ifdef PSCAN_LAST_EN
  assign last = w_scan && w_final;
`endif

endmodule

`default_nettype wire
